// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared core defines for the decode/issue hazard controller: the core bus
// widths, the default register-index width and in-flight limit, the hazard
// FSM state encoding and a small width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   // Core bus widths shared across the pipeline
   localparam int CORE_XLEN        = 32;
   localparam int CORE_ILEN        = 32;

   // Hazard controller defaults
   localparam int RS_W_DEFAULT     = 5;
   localparam int INFL_MAX_DEFAULT = 4;
   localparam int PERF_CNT_W       = 32;

   // Issue control FSM encoding
   typedef enum logic [1:0] {
      HAZ_RUN    = 2'd0,
      HAZ_SERIAL = 2'd1,
      HAZ_FLUSH  = 2'd2
   } hazState_e;

   // Width needed to hold the values 0..maxVal inclusive
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard
// Per-register pending-write counters (2 bits each) for registers
// 1..2^RS_W-1. Register x0 has no counter and always reads as zero.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_incEn, i_incIdx       a write to i_incIdx was issued this cycle
//   i_decEn, i_decIdx       a write to i_decIdx retired this cycle
//   i_rs1Idx/i_rs2Idx/i_rdIdx   read indices
//   o_rs1Cnt/o_rs2Cnt/o_rdCnt   pending count seen by decode this cycle
//
// The read ports already discount a retirement happening in the same cycle,
// so a dependent instruction can issue in the very cycle its producer
// leaves WB.
// ---------------------------------------------------------------------------
module pipe_scoreboard
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RS_W = RS_W_DEFAULT
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_incEn,
   input  logic [RS_W-1:0] i_incIdx,
   input  logic            i_decEn,
   input  logic [RS_W-1:0] i_decIdx,
   input  logic [RS_W-1:0] i_rs1Idx,
   input  logic [RS_W-1:0] i_rs2Idx,
   input  logic [RS_W-1:0] i_rdIdx,
   output logic [1:0]      o_rs1Cnt,
   output logic [1:0]      o_rs2Cnt,
   output logic [1:0]      o_rdCnt
);

   localparam int NREG = 1 << RS_W;

   logic [NREG-1:0][1:0] r_cnt;
   logic [NREG-1:0][1:0] w_cntNext;
   logic [NREG-1:0]      w_incHit;
   logic [NREG-1:0]      w_decHit;
   logic [1:0]           w_rs1Raw;
   logic [1:0]           w_rs2Raw;
   logic [1:0]           w_rdRaw;

   // One-hot select of the register being incremented / decremented;
   // x0 is excluded so its slot stays at zero forever.
   assign w_incHit = (i_incEn && (i_incIdx != '0)) ? (NREG'(1) << i_incIdx) : '0;
   assign w_decHit = (i_decEn && (i_decIdx != '0)) ? (NREG'(1) << i_decIdx) : '0;

   // Next counter values: an increment and decrement on the same register
   // cancel out; the saturation and underflow guards are belt-and-braces,
   // the controller never issues into a saturated counter.
   always_comb begin
      w_cntNext = r_cnt;
      for (int k = 1; k < NREG; k++) begin
         if (w_incHit[k] && !w_decHit[k] && (r_cnt[k] != 2'd3)) begin
            w_cntNext[k] = r_cnt[k] + 2'd1;
         end else if (!w_incHit[k] && w_decHit[k] && (r_cnt[k] != 2'd0)) begin
            w_cntNext[k] = r_cnt[k] - 2'd1;
         end
      end
   end

   // Counter storage
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cntNext;
      end
   end

   // Read ports with same-cycle retirement bypass
   always_comb begin
      w_rs1Raw = r_cnt[i_rs1Idx];
      w_rs2Raw = r_cnt[i_rs2Idx];
      w_rdRaw  = r_cnt[i_rdIdx];
      o_rs1Cnt = w_rs1Raw;
      o_rs2Cnt = w_rs2Raw;
      o_rdCnt  = w_rdRaw;
      if (w_decHit[i_rs1Idx] && (w_rs1Raw != 2'd0)) o_rs1Cnt = w_rs1Raw - 2'd1;
      if (w_decHit[i_rs2Idx] && (w_rs2Raw != 2'd0)) o_rs2Cnt = w_rs2Raw - 2'd1;
      if (w_decHit[i_rdIdx]  && (w_rdRaw  != 2'd0)) o_rdCnt  = w_rdRaw  - 2'd1;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Decode-stage issue gate. Holds decode while a source (or a saturated
// destination) has writes pending, while the ID..WB window is full, while a
// serializing op waits for the pipe to drain or is itself in flight, and
// kills IF/ID for two cycles when EX redirects.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   d_valid_i                     decode holds an instruction
//   d_rs1_used_i/d_rs2_used_i     source operands are read
//   d_rs1_i/d_rs2_i/d_rd_i        register indices
//   d_wenReg_i                    instruction writes d_rd_i
//   d_is_sys_i                    serializing op (CSR/ecall/mret/fence)
//   E_ready_i                     ID/EX can accept
//   E_valid_o                     gated valid to ID/EX; issue = E_valid_o & E_ready_i
//   d_stall_o                     hold IF/ID
//   wb_valid_i/wb_wenReg_i/wb_rd_i    retirement at WB
//   ex_redirect_i                 mispredict or trap resolved in EX
//   flush_o                       kill IF/ID
//   stall_cnt_o/flush_cnt_o       cycle counters, only with PIPE_HAZARD_PERF_EN
//
// Build option: define PIPE_HAZARD_PERF_EN to add the two 32-bit
// performance counters.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RS_W     = RS_W_DEFAULT,
   parameter int INFL_MAX = INFL_MAX_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  d_valid_i,
   input  logic                  d_rs1_used_i,
   input  logic                  d_rs2_used_i,
   input  logic                  d_wenReg_i,
   input  logic                  d_is_sys_i,
   input  logic [RS_W-1:0]       d_rs1_i,
   input  logic [RS_W-1:0]       d_rs2_i,
   input  logic [RS_W-1:0]       d_rd_i,
   input  logic                  E_ready_i,
   output logic                  E_valid_o,
   output logic                  d_stall_o,
   input  logic                  wb_valid_i,
   input  logic                  wb_wenReg_i,
   input  logic [RS_W-1:0]       wb_rd_i,
   input  logic                  ex_redirect_i,
`ifdef PIPE_HAZARD_PERF_EN
   output logic [PERF_CNT_W-1:0] stall_cnt_o,
   output logic [PERF_CNT_W-1:0] flush_cnt_o,
`endif
   output logic                  flush_o
);

   localparam int                INFL_W     = cntWidth(INFL_MAX);
   localparam logic [INFL_W-1:0] INFL_LIMIT = INFL_W'(INFL_MAX);

   hazState_e         r_state;
   hazState_e         w_stateNext;
   logic [INFL_W-1:0] r_inflight;
   logic [INFL_W-1:0] w_inflNext;

   logic [1:0]        w_rs1Cnt;
   logic [1:0]        w_rs2Cnt;
   logic [1:0]        w_rdCnt;
   logic              w_hazard;
   logic              w_full;
   logic              w_sysBlock;
   logic              w_eValid;
   logic              w_dStall;
   logic              w_flush;
   logic              w_issue;

   // Pending-write scoreboard: bumped on issue of a register write,
   // released when that write retires at WB.
   pipe_scoreboard #(
      .RS_W (RS_W)
   ) u_scoreboard (
      .i_clk    (clk_i),
      .i_rst_n  (rst_i),
      .i_incEn  (w_issue && d_wenReg_i),
      .i_incIdx (d_rd_i),
      .i_decEn  (wb_valid_i && wb_wenReg_i),
      .i_decIdx (wb_rd_i),
      .i_rs1Idx (d_rs1_i),
      .i_rs2Idx (d_rs2_i),
      .i_rdIdx  (d_rd_i),
      .o_rs1Cnt (w_rs1Cnt),
      .o_rs2Cnt (w_rs2Cnt),
      .o_rdCnt  (w_rdCnt)
   );

   // Data hazard: a used source still has a pending writer, or the
   // destination counter is saturated and cannot record another write.
   always_comb begin
      w_hazard = 1'b0;
      if (d_rs1_used_i && (d_rs1_i != '0) && (w_rs1Cnt != 2'd0)) w_hazard = 1'b1;
      if (d_rs2_used_i && (d_rs2_i != '0) && (w_rs2Cnt != 2'd0)) w_hazard = 1'b1;
      if (d_wenReg_i && (w_rdCnt == 2'd3))                      w_hazard = 1'b1;
   end

   assign w_full     = (r_inflight == INFL_LIMIT);
   assign w_sysBlock = d_is_sys_i && (r_inflight != '0);

   // Next state and issue gating. The redirect override sits last so it
   // beats issue and SERIAL entry; IF/ID is being killed, so it is not
   // also held.
   always_comb begin
      w_stateNext = r_state;
      w_eValid    = 1'b0;
      w_dStall    = 1'b0;
      w_flush     = 1'b0;
      case (r_state)
         HAZ_RUN: begin
            w_eValid = d_valid_i && !w_hazard && !w_full && !w_sysBlock;
            w_dStall = d_valid_i && !(w_eValid && E_ready_i);
            if (w_eValid && E_ready_i && d_is_sys_i) begin
               w_stateNext = HAZ_SERIAL;
            end
         end
         HAZ_SERIAL: begin
            w_dStall = d_valid_i;
            if (r_inflight == '0) begin
               w_stateNext = HAZ_RUN;
            end
         end
         HAZ_FLUSH: begin
            w_flush     = 1'b1;
            w_stateNext = HAZ_RUN;
         end
         default: begin
            w_stateNext = HAZ_RUN;
         end
      endcase
      if (ex_redirect_i) begin
         w_eValid    = 1'b0;
         w_dStall    = 1'b0;
         w_flush     = 1'b1;
         w_stateNext = HAZ_FLUSH;
      end
   end

   // Outputs are combinational, so reset must mask them directly to take
   // effect the instant rst_i drops.
   assign E_valid_o = rst_i && w_eValid;
   assign d_stall_o = rst_i && w_dStall;
   assign flush_o   = rst_i && w_flush;
   assign w_issue   = E_valid_o && E_ready_i;

   // In-flight window: +1 per issue, -1 per retirement, net zero when both.
   always_comb begin
      w_inflNext = r_inflight;
      if (w_issue && !wb_valid_i) begin
         w_inflNext = r_inflight + INFL_W'(1);
      end else if (!w_issue && wb_valid_i && (r_inflight != '0)) begin
         w_inflNext = r_inflight - INFL_W'(1);
      end
   end

   // State and in-flight registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= HAZ_RUN;
         r_inflight <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_inflight <= w_inflNext;
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   logic [PERF_CNT_W-1:0] r_stallCnt;
   logic [PERF_CNT_W-1:0] r_flushCnt;

   // Free-running stall/flush cycle counters, wrapping naturally
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (d_stall_o) r_stallCnt <= r_stallCnt + PERF_CNT_W'(1);
         if (flush_o)   r_flushCnt <= r_flushCnt + PERF_CNT_W'(1);
      end
   end

   assign stall_cnt_o = r_stallCnt;
   assign flush_cnt_o = r_flushCnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios for the hazard controller. Each row drives one cycle of
// decode/WB/redirect inputs together with the outputs expected for that
// cycle; the expectation is queued when the row is driven and checked when
// the DUT outputs settle at the following falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst_i;
   logic       d_valid_i, d_rs1_used_i, d_rs2_used_i, d_wenReg_i, d_is_sys_i;
   logic [4:0] d_rs1_i, d_rs2_i, d_rd_i;
   logic       E_ready_i;
   logic       E_valid_o, d_stall_o, flush_o;
   logic       wb_valid_i, wb_wenReg_i;
   logic [4:0] wb_rd_i;
   logic       ex_redirect_i;
`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

   typedef struct packed {
      logic       dv, r1u;
      logic [4:0] rs1;
      logic       r2u;
      logic [4:0] rs2;
      logic       wen;
      logic [4:0] rd;
      logic       sys, er, wbv;
      logic [4:0] wbrd;
      logic       redir;
      logic       ev, st, fl;
   } row_t;

   typedef struct packed {
      logic ev, st, fl;
   } exp_t;

   exp_t expQ[$];
   int   nChecks = 0;
   int   nFail   = 0;

   pipe_hazard_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .d_valid_i     (d_valid_i),
      .d_rs1_used_i  (d_rs1_used_i),
      .d_rs2_used_i  (d_rs2_used_i),
      .d_wenReg_i    (d_wenReg_i),
      .d_is_sys_i    (d_is_sys_i),
      .d_rs1_i       (d_rs1_i),
      .d_rs2_i       (d_rs2_i),
      .d_rd_i        (d_rd_i),
      .E_ready_i     (E_ready_i),
      .E_valid_o     (E_valid_o),
      .d_stall_o     (d_stall_o),
      .wb_valid_i    (wb_valid_i),
      .wb_wenReg_i   (wb_wenReg_i),
      .wb_rd_i       (wb_rd_i),
      .ex_redirect_i (ex_redirect_i),
`ifdef PIPE_HAZARD_PERF_EN
      .stall_cnt_o   (stall_cnt_o),
      .flush_cnt_o   (flush_cnt_o),
`endif
      .flush_o       (flush_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Row builder: dv r1u rs1 r2u rs2 wen rd sys er wbv wbrd redir | ev st fl
   function automatic row_t mkRow(input int dv, input int r1u, input int rs1,
                                  input int r2u, input int rs2, input int wen,
                                  input int rd, input int sys, input int er,
                                  input int wbv, input int wbrd, input int redir,
                                  input int ev, input int st, input int fl);
      row_t r;
      r.dv = 1'(dv);   r.r1u = 1'(r1u); r.rs1 = 5'(rs1);
      r.r2u = 1'(r2u); r.rs2 = 5'(rs2); r.wen = 1'(wen);
      r.rd = 5'(rd);   r.sys = 1'(sys); r.er = 1'(er);
      r.wbv = 1'(wbv); r.wbrd = 5'(wbrd); r.redir = 1'(redir);
      r.ev = 1'(ev);   r.st = 1'(st);   r.fl = 1'(fl);
      return r;
   endfunction

   task automatic clearInputs();
      d_valid_i = 0; d_rs1_used_i = 0; d_rs2_used_i = 0; d_wenReg_i = 0;
      d_is_sys_i = 0; d_rs1_i = 0; d_rs2_i = 0; d_rd_i = 0; E_ready_i = 0;
      wb_valid_i = 0; wb_wenReg_i = 0; wb_rd_i = 0; ex_redirect_i = 0;
   endtask

   // Drive one cycle just after the rising edge and queue its expectation
   task automatic applyStimulus(input row_t r);
      @(posedge clk);
      #1;
      d_valid_i = r.dv; d_rs1_used_i = r.r1u; d_rs1_i = r.rs1;
      d_rs2_used_i = r.r2u; d_rs2_i = r.rs2; d_wenReg_i = r.wen;
      d_rd_i = r.rd; d_is_sys_i = r.sys; E_ready_i = r.er;
      wb_valid_i = r.wbv; wb_wenReg_i = r.wbv; wb_rd_i = r.wbrd;
      ex_redirect_i = r.redir;
      expQ.push_back('{ev: r.ev, st: r.st, fl: r.fl});
   endtask

   task automatic test_reset();
      exp_t e;
      clearInputs();
      rst_i = 1'b0;
      d_valid_i = 1; E_ready_i = 1; ex_redirect_i = 1;
      expQ.push_back('{ev: 1'b0, st: 1'b0, fl: 1'b0});
      #2;
      e = expQ.pop_front();
      nChecks += 3;
      if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL reset E_valid_o got %b expected %b", E_valid_o, e.ev); end
      if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL reset d_stall_o got %b expected %b", d_stall_o, e.st); end
      if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL reset flush_o got %b expected %b", flush_o, e.fl); end
      @(negedge clk);
      clearInputs();
      rst_i = 1'b1;
   endtask

   task automatic test_raw();
      row_t rows[$];
      exp_t e;
      rows.push_back(mkRow(1,0,0,0,0,1,5,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(1,1,5,0,0,1,6,0,1,0,0,0, 0,1,0));
      rows.push_back(mkRow(1,1,5,0,0,1,6,0,1,0,0,0, 0,1,0));
      rows.push_back(mkRow(1,1,5,0,0,1,6,0,1,1,5,0, 1,0,0));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,6,0, 0,0,0));
      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = expQ.pop_front();
         nChecks += 3;
         if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL raw[%0d] E_valid_o got %b expected %b", i, E_valid_o, e.ev); end
         if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL raw[%0d] d_stall_o got %b expected %b", i, d_stall_o, e.st); end
         if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL raw[%0d] flush_o got %b expected %b", i, flush_o, e.fl); end
      end
   endtask

   task automatic test_saturation();
      row_t rows[$];
      exp_t e;
      for (int k = 0; k < 3; k++) rows.push_back(mkRow(1,0,0,0,0,1,7,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(1,0,0,0,0,1,7,0,1,0,0,0, 0,1,0));
      rows.push_back(mkRow(1,0,0,0,0,1,7,0,1,0,0,0, 0,1,0));
      rows.push_back(mkRow(1,0,0,0,0,1,7,0,1,1,7,0, 1,0,0));
      for (int k = 0; k < 3; k++) rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,7,0, 0,0,0));
      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = expQ.pop_front();
         nChecks += 3;
         if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL sat[%0d] E_valid_o got %b expected %b", i, E_valid_o, e.ev); end
         if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL sat[%0d] d_stall_o got %b expected %b", i, d_stall_o, e.st); end
         if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL sat[%0d] flush_o got %b expected %b", i, flush_o, e.fl); end
      end
   endtask

   task automatic test_full();
      row_t rows[$];
      exp_t e;
      rows.push_back(mkRow(1,0,0,0,0,1,3,0,0,0,0,0, 1,1,0));
      rows.push_back(mkRow(1,1,3,0,0,0,0,0,1,0,0,0, 1,0,0));
      for (int k = 0; k < 3; k++) rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 0,1,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,1,0,0, 0,1,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 1,0,0));
      for (int k = 0; k < 4; k++) rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0));
      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = expQ.pop_front();
         nChecks += 3;
         if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL full[%0d] E_valid_o got %b expected %b", i, E_valid_o, e.ev); end
         if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL full[%0d] d_stall_o got %b expected %b", i, d_stall_o, e.st); end
         if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL full[%0d] flush_o got %b expected %b", i, flush_o, e.fl); end
      end
   endtask

   task automatic test_serial();
      row_t rows[$];
      exp_t e;
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,1,1,0,0,0, 0,1,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,1,1,1,0,0, 0,1,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,1,1,1,0,0, 0,1,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,1,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 0,1,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,1,0,0, 0,1,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 0,1,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0));
      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = expQ.pop_front();
         nChecks += 3;
         if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL serial[%0d] E_valid_o got %b expected %b", i, E_valid_o, e.ev); end
         if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL serial[%0d] d_stall_o got %b expected %b", i, d_stall_o, e.st); end
         if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL serial[%0d] flush_o got %b expected %b", i, flush_o, e.fl); end
      end
   endtask

   task automatic test_redirect();
      row_t rows[$];
      exp_t e;
      rows.push_back(mkRow(1,0,0,0,0,1,4,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,1,4,1, 0,0,1));
      rows.push_back(mkRow(1,1,4,0,0,0,0,0,1,0,0,0, 0,0,1));
      rows.push_back(mkRow(1,1,4,0,0,0,0,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,1,1,0,0,1, 0,0,1));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0));
      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = expQ.pop_front();
         nChecks += 3;
         if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL redirect[%0d] E_valid_o got %b expected %b", i, E_valid_o, e.ev); end
         if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL redirect[%0d] d_stall_o got %b expected %b", i, d_stall_o, e.st); end
         if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL redirect[%0d] flush_o got %b expected %b", i, flush_o, e.fl); end
      end
   endtask

   task automatic test_back_to_back();
      row_t rows[$];
      exp_t e;
      rows.push_back(mkRow(1,0,0,0,0,1,9,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(1,0,0,0,0,1,9,0,1,1,9,0, 1,0,0));
      rows.push_back(mkRow(1,1,9,0,0,0,0,0,1,0,0,0, 0,1,0));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,9,0, 0,0,0));
      rows.push_back(mkRow(1,0,0,1,9,0,0,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0));
      rows.push_back(mkRow(1,0,0,0,0,1,0,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(1,1,0,1,0,0,0,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0));
      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = expQ.pop_front();
         nChecks += 3;
         if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL b2b[%0d] E_valid_o got %b expected %b", i, E_valid_o, e.ev); end
         if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL b2b[%0d] d_stall_o got %b expected %b", i, d_stall_o, e.st); end
         if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL b2b[%0d] flush_o got %b expected %b", i, flush_o, e.fl); end
      end
   endtask

   task automatic test_reset_serial();
      row_t rows[$];
      exp_t e;
      rows.push_back(mkRow(1,0,0,0,0,0,0,1,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 0,1,0));
      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = expQ.pop_front();
         nChecks += 3;
         if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL rstser[%0d] E_valid_o got %b expected %b", i, E_valid_o, e.ev); end
         if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL rstser[%0d] d_stall_o got %b expected %b", i, d_stall_o, e.st); end
         if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL rstser[%0d] flush_o got %b expected %b", i, flush_o, e.fl); end
      end
      // Reset asserted mid-cycle while SERIAL, with decode valid and a redirect
      @(posedge clk);
      #1;
      d_valid_i = 1; E_ready_i = 1; ex_redirect_i = 1;
      #1;
      rst_i = 1'b0;
      expQ.push_back('{ev: 1'b0, st: 1'b0, fl: 1'b0});
      #1;
      e = expQ.pop_front();
      nChecks += 3;
      if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL rstmid E_valid_o got %b expected %b", E_valid_o, e.ev); end
      if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL rstmid d_stall_o got %b expected %b", d_stall_o, e.st); end
      if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL rstmid flush_o got %b expected %b", flush_o, e.fl); end
      @(negedge clk);
      clearInputs();
      rst_i = 1'b1;
      // Back in RUN with an empty window: a plain instruction issues at once
      rows.delete();
      rows.push_back(mkRow(1,0,0,0,0,0,0,0,1,0,0,0, 1,0,0));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0));
      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = expQ.pop_front();
         nChecks += 3;
         if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL rstrun[%0d] E_valid_o got %b expected %b", i, E_valid_o, e.ev); end
         if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL rstrun[%0d] d_stall_o got %b expected %b", i, d_stall_o, e.st); end
         if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL rstrun[%0d] flush_o got %b expected %b", i, flush_o, e.fl); end
      end
   endtask

`ifdef PIPE_HAZARD_PERF_EN
   task automatic test_perf();
      row_t rows[$];
      exp_t e;
      @(negedge clk);
      clearInputs();
      rst_i = 1'b0;
      #2;
      rst_i = 1'b1;
      rows.push_back(mkRow(1,0,0,0,0,1,5,0,1,0,0,0, 1,0,0));
      for (int k = 0; k < 10; k++) rows.push_back(mkRow(1,1,5,0,0,0,0,0,1,0,0,0, 0,1,0));
      rows.push_back(mkRow(1,1,5,0,0,0,0,0,1,1,5,0, 1,0,0));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,0,0,1, 0,0,1));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
      rows.push_back(mkRow(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0));
      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = expQ.pop_front();
         nChecks += 3;
         if (E_valid_o !== e.ev) begin nFail++; $display("[TB] FAIL perf[%0d] E_valid_o got %b expected %b", i, E_valid_o, e.ev); end
         if (d_stall_o !== e.st) begin nFail++; $display("[TB] FAIL perf[%0d] d_stall_o got %b expected %b", i, d_stall_o, e.st); end
         if (flush_o !== e.fl)   begin nFail++; $display("[TB] FAIL perf[%0d] flush_o got %b expected %b", i, flush_o, e.fl); end
      end
      @(posedge clk);
      #1;
      nChecks += 2;
      if (stall_cnt_o !== 32'd10) begin nFail++; $display("[TB] FAIL perf stall_cnt_o got %0d expected 10", stall_cnt_o); end
      if (flush_cnt_o !== 32'd2)  begin nFail++; $display("[TB] FAIL perf flush_cnt_o got %0d expected 2", flush_cnt_o); end
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before end of test");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      clearInputs();
      rst_i = 1'b0;
      test_reset();
      test_raw();
      test_saturation();
      test_full();
      test_serial();
      test_redirect();
      test_back_to_back();
      test_reset_serial();
`ifdef PIPE_HAZARD_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
